io_bus_bridge: RTL and testbench
================================

IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
- REQ-001 Parameter TIMEOUT_CYCLES, default 1200000, inter-byte timeout in clk cycles (100 ms at 12 MHz).
- REQ-002 clk  input  1  single system clock; all logic on rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset.
- REQ-004 rx_valid  input  1  UART RX byte available; held until consumed.
- REQ-005 rx_data  input  8  UART RX byte; valid while rx_valid=1.
- REQ-006 rx_rd  output  1  one-cycle pulse that consumes the current RX byte.
- REQ-007 tx_busy  input  1  UART TX busy.
- REQ-008 tx_wr  output  1  one-cycle pulse that launches tx_data.
- REQ-009 tx_data  output  8  byte to transmit.
- REQ-010 bus_req  output  1  request for IO bus ownership.
- REQ-011 bus_gnt  input  1  IO bus granted; CPU is stalled while it is high.
- REQ-012 io_rd, io_wr  output  1 each  IO strobes, same meaning as on the CPU IO bus.
- REQ-013 io_addr, io_dout  output  16 each  IO address and write data.
- REQ-014 io_din  input  16  IO read data, combinationally valid in the io_rd cycle.

Function
- REQ-015 Protocol: 'W' (0x57) + addr_hi, addr_lo, data_hi, data_lo performs one IO write, then replies ACK 0x06.
- REQ-016 Protocol: 'R' (0x52) + addr_hi, addr_lo performs one IO read, then replies data_hi, data_lo.
- REQ-017 Any other byte in IDLE: consumed, replied NAK 0x15, state stays IDLE.
- REQ-018 States: IDLE, ARGS, REQ, ACCESS, TX_WAIT, TX_GAP; IDLE->ARGS on valid command byte.
- REQ-019 ARGS collects 4 (W) or 2 (R) argument bytes big-endian; ARGS->REQ after the last one.
- REQ-020 REQ: bus_req=1 until bus_gnt=1; REQ->ACCESS in the cycle after bus_gnt is sampled high.
- REQ-021 ACCESS lasts exactly one cycle: io_wr or io_rd =1, bus_req held; io_din captured at the end of that cycle.
- REQ-022 bus_req drops in the cycle after ACCESS; exactly one strobe per command.
- REQ-023 io_addr/io_dout hold their last value outside ACCESS; strobes are 0 outside ACCESS.
- REQ-024 RX consumption: rx_rd pulses for one cycle when rx_valid=1 in IDLE/ARGS; rx_valid is ignored in the cycle after rx_rd.
- REQ-025 TX_WAIT: when tx_busy=0, tx_wr pulses one cycle with tx_data set; then TX_GAP for one cycle (busy latency); then next reply byte or IDLE.
- REQ-026 RX bytes arriving during REQ/ACCESS/TX are left unconsumed (rx_rd=0) until IDLE.
- REQ-027 bus_gnt never arriving: bridge waits in REQ indefinitely; no timeout in REQ.

Reset
- REQ-028 Reset forces IDLE; rx_rd, tx_wr, bus_req, io_rd, io_wr =0; io_addr, io_dout, tx_data =0; byte count cleared.
- REQ-029 Reset mid-command discards partial arguments; reset during ACCESS deasserts strobes in the next cycle; no reply is sent.

Configuration
- REQ-030 Macro IO_BUS_BRIDGE_TIMEOUT_EN defined: in ARGS, a counter reloads on every consumed byte; TIMEOUT_CYCLES cycles without a byte -> IDLE, partial command dropped, NAK 0x15 sent.
- REQ-031 Macro not defined: no counter; ARGS waits indefinitely.

Verification
- REQ-032 Bytes 57 40 00 12 34, bus_gnt tied 1 -> one io_wr cycle with io_addr=0x4000, io_dout=0x1234; then TX 0x06.
- REQ-033 Bytes 52 20 00, io_din=0x0003 in the access cycle -> one io_rd cycle with io_addr=0x2000; TX 0x00 then 0x03.
- REQ-034 Byte 0x41 -> TX 0x15, no strobes, state IDLE.
- REQ-035 bus_gnt held 0 for 50 cycles after the last arg -> bus_req=1 and no strobe during them; strobe occurs in the cycle after bus_gnt rises.
- REQ-036 tx_busy held 1 for 200 cycles -> no tx_wr until it falls; second reply byte only after the TX_GAP cycle.
- REQ-037 With timeout enabled and TIMEOUT_CYCLES=100, bytes 57 40 then silence -> IDLE plus TX 0x15 after 100 cycles, no io_wr; reset after 57 -> no reply.

Source files
------------

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: UART command bridge onto the CPU IO bus ('W' write / 'R' read, ACK/NAK replies).
// Defining IO_BUS_BRIDGE_TIMEOUT_EN adds an inter-byte timeout while collecting arguments.
module io_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_busy,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] io_addr,
    output logic [15:0] io_dout,
    input  logic [15:0] io_din
);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RespAck  = 8'h06;
    localparam logic [7:0] RespNak  = 8'h15;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("io_bus_bridge: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {
        StIdle,
        StArgs,
        StReq,
        StAccess,
        StTxWait,
        StTxGap
    } state_e;

    state_e      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  arg_cnt_q, arg_cnt_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  rd_lo_q, rd_lo_d;
    logic        more_q, more_d;
    logic        rx_skip_q;
    logic        rx_take;
    logic        tmo_hit;

`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q;

    // Restarts on every consumed byte; only runs while collecting arguments.
    always_ff @(posedge clk) begin
        if (reset || (state_q != StArgs) || rx_rd) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == StArgs) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // The UART may still show the consumed byte for one cycle after rx_rd.
    assign rx_take = rx_valid && !rx_skip_q && !reset;

    assign io_addr = addr_q;
    assign io_dout = dout_q;
    assign tx_data = tx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            arg_cnt_q  <= 2'd0;
            arg_q      <= 32'h0;
            addr_q     <= 16'h0;
            dout_q     <= 16'h0;
            tx_data_q  <= 8'h0;
            rd_lo_q    <= 8'h0;
            more_q     <= 1'b0;
            rx_skip_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            arg_cnt_q  <= arg_cnt_d;
            arg_q      <= arg_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            tx_data_q  <= tx_data_d;
            rd_lo_q    <= rd_lo_d;
            more_q     <= more_d;
            rx_skip_q  <= rx_rd;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        arg_cnt_d  = arg_cnt_q;
        arg_d      = arg_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        tx_data_d  = tx_data_q;
        rd_lo_d    = rd_lo_q;
        more_d     = more_q;
        rx_rd      = 1'b0;
        tx_wr      = 1'b0;
        bus_req    = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_take) begin
                    rx_rd = 1'b1;
                    if ((rx_data == CmdWrite) || (rx_data == CmdRead)) begin
                        is_write_d = (rx_data == CmdWrite);
                        arg_cnt_d  = 2'd0;
                        state_d    = StArgs;
                    end else begin
                        tx_data_d = RespNak;
                        more_d    = 1'b0;
                        state_d   = StTxWait;
                    end
                end
            end
            StArgs: begin
                if (rx_take) begin
                    rx_rd     = 1'b1;
                    arg_d     = {arg_q[23:0], rx_data};
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    if (arg_cnt_q == (is_write_q ? 2'd3 : 2'd1)) begin
                        state_d = StReq;
                    end
                end else if (tmo_hit) begin
                    tx_data_d = RespNak;
                    more_d    = 1'b0;
                    state_d   = StTxWait;
                end
            end
            StReq: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    // Address/data only move at the start of the access cycle.
                    addr_d  = is_write_q ? arg_q[31:16] : arg_q[15:0];
                    if (is_write_q) begin
                        dout_d = arg_q[15:0];
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                bus_req = 1'b1;
                io_wr   = is_write_q;
                io_rd   = !is_write_q;
                if (is_write_q) begin
                    tx_data_d = RespAck;
                    more_d    = 1'b0;
                end else begin
                    tx_data_d = io_din[15:8];
                    rd_lo_d   = io_din[7:0];
                    more_d    = 1'b1;
                end
                state_d = StTxWait;
            end
            StTxWait: begin
                if (!tx_busy && !reset) begin
                    tx_wr   = 1'b1;
                    state_d = StTxGap;
                end
            end
            StTxGap: begin
                // One idle cycle lets the UART raise tx_busy before we look again.
                if (more_q) begin
                    tx_data_d = rd_lo_q;
                    more_d    = 1'b0;
                    state_d   = StTxWait;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: vector table, hand-written corner sequences and
// randomized command streams scored against a command-level reference model.
module tb_io_bus_bridge;

    localparam int unsigned Tmo = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        tx_busy;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        bus_req;
    logic        bus_gnt;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;

    io_bus_bridge #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .tx_busy  (tx_busy),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .io_addr  (io_addr),
        .io_dout  (io_dout),
        .io_din   (io_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        int          nb;
        logic [39:0] b;
        int          n_acc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dout;
        int          n_tx;
        logic [15:0] tx;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    acc_t       acc_q[$];
    logic [7:0] exp_tx[$];
    acc_t       exp_acc[$];

    logic        rst_drv = 1'b1;
    int          gnt_mode = 0;
    logic        busy_force = 1'b0;
    logic        busy_rand = 1'b0;
    int          busy_len = 3;
    int          busy_cnt = 0;
    logic        in_stale = 1'b0;
    logic        saw_rd = 1'b0;
    logic        saw_tx = 1'b0;
    int          last_rd_cyc = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_reset = 1'b1;
    logic [15:0] prev_addr = 16'h0;
    logic [15:0] prev_dout = 16'h0;

    vec_t vecs[6];

    function automatic logic [15:0] dev(input logic [15:0] a);
        if (a == 16'h2000) return 16'h0003;
        return {a[7:0], a[15:8]} ^ 16'h5AA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe();
        saw_rd = rx_rd;
        saw_tx = tx_wr;
        if (rx_rd) begin
            check("rx_rd_in_skip_cycle", 32'(in_stale), 0);
            last_rd_cyc = cyc;
        end
        if (tx_wr) begin
            check("tx_wr_while_busy", 32'(tx_busy), 0);
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        if (io_wr || io_rd) begin
            check("strobe_one_hot", 32'(io_wr & io_rd), 0);
            check("strobe_with_bus_req", 32'(bus_req), 1);
            acc_q.push_back('{io_wr, io_addr, io_dout});
        end
        if (prev_strobe) check("bus_req_drop_after_access", 32'(bus_req), 0);
        if (!prev_reset && ((io_addr !== prev_addr) || (io_dout !== prev_dout)))
            check("io_addr_dout_hold", 32'(io_wr | io_rd), 1);
        prev_strobe = io_wr | io_rd;
        prev_reset  = reset;
        prev_addr   = io_addr;
        prev_dout   = io_dout;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        reset = rst_drv;
        if (saw_rd && rx_q.size() > 0) begin
            // Stale-valid UART: the consumed byte stays visible for one more cycle.
            rx_data  = rx_q.pop_front();
            rx_valid = 1'b1;
            in_stale = 1'b1;
        end else begin
            in_stale = 1'b0;
            rx_valid = (rx_q.size() > 0);
            rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
        if (saw_tx) busy_cnt = busy_rand ? int'($urandom_range(0, 12)) : busy_len;
        tx_busy = busy_force || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        case (gnt_mode)
            0:       bus_gnt = 1'b1;
            1:       bus_gnt = 1'b0;
            default: bus_gnt = ($urandom_range(0, 3) == 0);
        endcase
        io_din = io_rd ? dev(io_addr) : 16'($urandom);
        @(negedge clk);
        observe();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_q.size() < n; i++) step();
    endtask

    task automatic drain_rx(input int budget);
        for (int i = 0; i < budget && rx_q.size() > 0; i++) step();
        step();
    endtask

    task automatic push_bytes(input logic [39:0] b, input int n);
        for (int i = 0; i < n; i++) rx_q.push_back(b[39-8*i -: 8]);
    endtask

    task automatic clr();
        acc_q.delete();
        tx_q.delete();
        tx_cyc.delete();
    endtask

    task automatic pulse_reset();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        step();
    endtask

    task automatic check_tx2(input string name, input logic [7:0] b0, input logic [7:0] b1);
        check({name, "_tx_count"}, tx_q.size(), 2);
        if (tx_q.size() == 2) begin
            check({name, "_tx0"}, tx_q[0], b0);
            check({name, "_tx1"}, tx_q[1], b1);
        end
    endtask

    task automatic check_write(input string name, input logic [15:0] a, input logic [15:0] d);
        check({name, "_acc_count"}, acc_q.size(), 1);
        if (acc_q.size() == 1) begin
            check({name, "_is_write"}, acc_q[0].wr, 1);
            check({name, "_addr"}, acc_q[0].addr, a);
            check({name, "_dout"}, acc_q[0].data, d);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 90000", cyc);
        $fatal(1, "watchdog");
    end

    int          bad;
    int          kind;
    int          lat;
    int          nmin;
    logic [15:0] ra;
    logic [15:0] rdat;
    logic [15:0] rv;
    logic [7:0]  junk;

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        bus_gnt = 1'b1; io_din = 16'h0;

        // Reset state
        steps(3);
        rst_drv = 1'b0;
        step();
        check("reset_rx_rd", rx_rd, 0);
        check("reset_tx_wr", tx_wr, 0);
        check("reset_bus_req", bus_req, 0);
        check("reset_io_rd", io_rd, 0);
        check("reset_io_wr", io_wr, 0);
        check("reset_io_addr", io_addr, 0);
        check("reset_io_dout", io_dout, 0);
        check("reset_tx_data", tx_data, 0);

        // Vector table: bytes in, expected strobe and reply bytes out
        vecs[0] = '{5, 40'h57_40_00_12_34, 1, 1'b1, 16'h4000, 16'h1234, 1, 16'h0600};
        vecs[1] = '{3, 40'h52_20_00_00_00, 1, 1'b0, 16'h2000, 16'h1234, 2, 16'h0003};
        vecs[2] = '{1, 40'h41_00_00_00_00, 0, 1'b0, 16'h0000, 16'h0000, 1, 16'h1500};
        vecs[3] = '{5, 40'h57_FF_FF_AB_CD, 1, 1'b1, 16'hFFFF, 16'hABCD, 1, 16'h0600};
        vecs[4] = '{3, 40'h52_FF_FE_00_00, 1, 1'b0, 16'hFFFE, 16'hABCD, 2, 16'hA45A};
        vecs[5] = '{1, 40'h00_00_00_00_00, 0, 1'b0, 16'h0000, 16'h0000, 1, 16'h1500};
        gnt_mode = 0; busy_rand = 1'b0; busy_len = 3;
        for (int v = 0; v < 6; v++) begin
            clr();
            push_bytes(vecs[v].b, vecs[v].nb);
            run_until_tx(vecs[v].n_tx, 200);
            steps(6);
            check($sformatf("vec%0d_acc_count", v), acc_q.size(), vecs[v].n_acc);
            if (acc_q.size() == 1 && vecs[v].n_acc == 1) begin
                check($sformatf("vec%0d_is_write", v), acc_q[0].wr, vecs[v].wr);
                check($sformatf("vec%0d_addr", v), acc_q[0].addr, vecs[v].addr);
                check($sformatf("vec%0d_dout", v), acc_q[0].data, vecs[v].dout);
            end
            check($sformatf("vec%0d_tx_count", v), tx_q.size(), vecs[v].n_tx);
            if (tx_q.size() >= 1) check($sformatf("vec%0d_tx0", v), tx_q[0], vecs[v].tx[15:8]);
            if (tx_q.size() >= 2 && vecs[v].n_tx == 2)
                check($sformatf("vec%0d_tx1", v), tx_q[1], vecs[v].tx[7:0]);
        end

        // Grant withheld for 50 cycles, then strobe in the cycle after grant
        clr();
        gnt_mode = 1;
        push_bytes(40'h52_12_34_00_00, 3);
        for (int i = 0; i < 50 && !bus_req; i++) step();
        check("gnt_wait_bus_req_up", bus_req, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!bus_req || io_rd || io_wr) bad++;
        end
        check("gnt_wait_bad_cycles", bad, 0);
        gnt_mode = 0;
        step();
        check("gnt_cycle_no_strobe", io_rd, 0);
        step();
        check("gnt_next_cycle_io_rd", io_rd, 1);
        check("gnt_next_cycle_addr", io_addr, 16'h1234);
        step();
        check("gnt_bus_req_dropped", bus_req, 0);
        run_until_tx(2, 200);
        check_tx2("gnt_reply", 8'h6E, 8'hB7);

        // tx_busy held for 200 cycles, then reply gap
        clr();
        busy_force = 1'b1;
        push_bytes(40'h57_00_01_00_02, 5);
        steps(200);
        check("busy_no_tx_while_held", tx_q.size(), 0);
        check_write("busy_write", 16'h0001, 16'h0002);
        busy_force = 1'b0; busy_len = 0;
        run_until_tx(1, 3);
        check("busy_release_tx_count", tx_q.size(), 1);
        if (tx_q.size() == 1) check("busy_release_ack", tx_q[0], 8'h06);
        clr();
        push_bytes(40'h52_20_00_00_00, 3);
        run_until_tx(2, 100);
        check_tx2("gap_reply", 8'h00, 8'h03);
        if (tx_cyc.size() == 2) check("gap_tx_spacing", tx_cyc[1] - tx_cyc[0], 2);

        // Reset mid-arguments discards the partial command
        clr();
        busy_len = 3;
        push_bytes(40'h57_40_00_00_00, 3);
        drain_rx(20);
        pulse_reset();
        check("rst_args_io_addr", io_addr, 0);
        check("rst_args_io_dout", io_dout, 0);
        check("rst_args_tx_data", tx_data, 0);
        steps(30);
        check("rst_args_no_tx", tx_q.size(), 0);
        check("rst_args_no_access", acc_q.size(), 0);
        push_bytes(40'h52_20_00_00_00, 3);
        run_until_tx(2, 100);
        check_tx2("rst_args_read", 8'h00, 8'h03);
        check("rst_args_read_acc", acc_q.size(), 1);
        if (acc_q.size() == 1) check("rst_args_read_addr", acc_q[0].addr, 16'h2000);

        // Reset right after the command byte: no reply even past the timeout
        clr();
        push_bytes(40'h57_00_00_00_00, 1);
        drain_rx(10);
        pulse_reset();
        steps(Tmo + 50);
        check("rst_cmd_no_reply", tx_q.size(), 0);

        // Reset during the access cycle
        clr();
        gnt_mode = 1;
        push_bytes(40'h57_11_22_33_44, 5);
        for (int i = 0; i < 50 && !bus_req; i++) step();
        gnt_mode = 0;
        step();
        rst_drv = 1'b1;
        step();
        check("rst_access_strobe_in_cycle", io_wr, 1);
        rst_drv = 1'b0;
        step();
        check("rst_access_strobe_gone", io_wr, 0);
        check("rst_access_bus_req_gone", bus_req, 0);
        steps(30);
        check("rst_access_no_reply", tx_q.size(), 0);

        // Inter-byte timeout behaviour
        clr();
        busy_len = 0;
        push_bytes(40'h57_40_00_00_00, 2);
`ifdef IO_BUS_BRIDGE_TIMEOUT_EN
        run_until_tx(1, 3 * Tmo);
        check("tmo_tx_count", tx_q.size(), 1);
        if (tx_q.size() == 1) begin
            check("tmo_nak", tx_q[0], 8'h15);
            lat = tx_cyc[0] - last_rd_cyc;
            check("tmo_latency_in_window", 32'((lat >= Tmo) && (lat <= Tmo + 2)), 1);
        end
        check("tmo_no_access", acc_q.size(), 0);
        clr();
        push_bytes(40'h57_40_00_12_34, 5);
`else
        steps(3 * Tmo);
        check("notmo_no_tx", tx_q.size(), 0);
        check("notmo_no_access", acc_q.size(), 0);
        push_bytes(40'h00_12_34_00_00, 3);
`endif
        run_until_tx(1, 100);
        check_write("after_silence_write", 16'h4000, 16'h1234);
        check("after_silence_tx_count", tx_q.size(), 1);
        if (tx_q.size() == 1) check("after_silence_ack", tx_q[0], 8'h06);

        // Random command stream against the command-level model
        clr();
        exp_acc.delete();
        exp_tx.delete();
        gnt_mode = 2; busy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 3));
            ra   = 16'($urandom);
            rdat = 16'($urandom);
            if (kind <= 1) begin
                push_bytes({8'h57, ra, rdat}, 5);
                exp_acc.push_back('{1'b1, ra, rdat});
                exp_tx.push_back(8'h06);
            end else if (kind == 2) begin
                push_bytes({8'h52, ra, 16'h0}, 3);
                exp_acc.push_back('{1'b0, ra, 16'h0});
                rv = dev(ra);
                exp_tx.push_back(rv[15:8]);
                exp_tx.push_back(rv[7:0]);
            end else begin
                do junk = 8'($urandom); while (junk == 8'h57 || junk == 8'h52);
                push_bytes({junk, 32'h0}, 1);
                exp_tx.push_back(8'h15);
            end
        end
        run_until_tx(exp_tx.size(), 20000);
        steps(20);
        check("rand_acc_count", acc_q.size(), exp_acc.size());
        check("rand_tx_count", tx_q.size(), exp_tx.size());
        nmin = (acc_q.size() < exp_acc.size()) ? acc_q.size() : exp_acc.size();
        for (int i = 0; i < nmin; i++) begin
            check($sformatf("rand_acc%0d_wr", i), acc_q[i].wr, exp_acc[i].wr);
            check($sformatf("rand_acc%0d_addr", i), acc_q[i].addr, exp_acc[i].addr);
            if (exp_acc[i].wr) check($sformatf("rand_acc%0d_dout", i), acc_q[i].data,
                                     exp_acc[i].data);
        end
        nmin = (tx_q.size() < exp_tx.size()) ? tx_q.size() : exp_tx.size();
        for (int i = 0; i < nmin; i++) check($sformatf("rand_tx%0d", i), tx_q[i], exp_tx[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
